calc_op_arbiter: RTL and testbench
==================================

// Module: calc_op_arbiter
// PURPOSE
//  Shares one iterative calculator unit (log/div-style, multi-cycle) among N_REQ requesters.
//  Arbitrates requests and sequences each operation: operand load, start pulse, wait for done
//  (with timeout), and per-requester response.
//  Sits between the keypad/display front-ends and the shared arithmetic unit.
// PARAMETERS
//  N_REQ   4   number of requesters (2..8)
//  DATA_W  7   operand/result width
//  TIMEOUT 15  max WAIT cycles without unit_done before error response (1..255)
// PORTS
//  clk          in   1             single clock, rising edge
//  rst          in   1             asynchronous, active-low reset
//  req          in   N_REQ         per-requester request level
//  req_a        in   N_REQ*DATA_W  operands, requester i at [i*DATA_W +: DATA_W]
//  gnt          out  N_REQ         one-hot grant, held for START..RESP
//  rsp_valid    out  N_REQ         one-cycle response pulse to granted requester
//  rsp_data     out  DATA_W        result, valid while rsp_valid!=0, held until next response
//  rsp_err      out  1             1 = timeout, qualified by rsp_valid
//  busy         out  1             high in any state except IDLE
//  unit_start   out  1             one-cycle start pulse to shared unit
//  unit_a       out  DATA_W        operand to unit, stable from START until next grant
//  unit_done    in   1             unit completion, sampled only in WAIT
//  unit_result  in   DATA_W        unit result, sampled with unit_done
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; gnt, rsp_valid, rsp_data, rsp_err, busy, unit_start, unit_a = 0;
//    rr pointer last=N_REQ-1, so req[0] wins first. Reset mid-op aborts: no rsp_valid is issued.
//  - All outputs registered. FSM: IDLE -> START -> WAIT -> RESP -> IDLE.
//  - IDLE: req sampled only here. If req!=0, winner idx = first set bit scanning last+1, last+2, .. mod N_REQ.
//    At the same edge: gnt=onehot(idx), unit_a=req_a slice idx, busy=1, go START.
//  - START (1 cycle): unit_start=1; timer cleared; go WAIT.
//  - WAIT: unit_done=1 -> rsp_data=unit_result, rsp_err=0, go RESP.
//    Else timer+1. At the TIMEOUT-th cycle without done: rsp_data=0, rsp_err=1, go RESP.
//    If done and timeout coincide, done wins.
//  - RESP (1 cycle): rsp_valid=onehot(idx); last=idx; go IDLE.
//    Leaving RESP clears gnt, rsp_valid and busy; rsp_data/rsp_err hold.
//  - Min latency: req sampled at edge 0 -> unit_start cycle 0..1.
//    done seen at edge 2 -> rsp_valid cycle 2..3. Next grant at edge 4 earliest.
//  - Requester dropping req after grant does not abort; its response pulse is still issued
//    and the rr pointer still advances.
//  - req changes outside IDLE are ignored; req_a is captured once, at grant.
//  - unit_done outside WAIT is ignored; timer width = clog2(TIMEOUT+1), never wraps.
// CONFIGURATION
//  CALC_ARB_FIXED_PRIO_EN defined: fixed priority, lowest set req index wins; rr pointer removed.
//  Undefined (default): round-robin as above. All other behaviour identical.
// TESTING
//  1. req=0001, a0=8, unit done 2 cycles after start with result 3
//     -> gnt=0001, one unit_start with unit_a=8, rsp_valid=0001, rsp_data=3, rsp_err=0.
//  2. req=0101 held, unit done immediately -> grants alternate 0,2,0,2.
//     With CALC_ARB_FIXED_PRIO_EN: grants 0,0,0.
//  3. req=0010, unit_done never -> rsp_valid=0010 after 15 WAIT cycles, rsp_err=1, rsp_data=0.
//  4. unit_done asserted on exactly the 15th WAIT cycle, result 5 -> rsp_err=0, rsp_data=5.
//  5. rst=0 during WAIT -> all outputs 0 immediately, no rsp_valid.
//     After release, req=1111 -> first gnt=0001.
//  6. req=1000 dropped in WAIT -> rsp_valid=1000 still pulses.
//     Then req=1001 -> next gnt=0001 (pointer advanced past 3).

Source files
------------

// File: rtl/calc_op_arbiter.sv
// Shares one multi-cycle calculator unit among N_REQ requesters: arbitrate, start, wait/timeout, respond.
// Optional CALC_ARB_FIXED_PRIO_EN selects lowest-index fixed priority instead of round-robin.
module calc_op_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 7,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_a,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      unit_start,
    output logic [DATA_W-1:0]         unit_a,
    input  logic                      unit_done,
    input  logic [DATA_W-1:0]         unit_result
);

    localparam int          IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int          TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned NR    = N_REQ;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                busy_q, busy_d;
    logic                unit_start_q, unit_start_d;
    logic [DATA_W-1:0]   unit_a_q, unit_a_d;
    logic [TMR_W-1:0]    timer_q, timer_d;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;

`ifdef CALC_ARB_FIXED_PRIO_EN
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (!win_found && req[k]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    // Scan starts just past the last served requester, wrapping modulo N_REQ.
    always_comb begin
        int unsigned p;
        win_found = 1'b0;
        win_idx   = '0;
        p         = 0;
        for (int unsigned k = 1; k <= NR; k++) begin
            p = (int'(last_q) + k) % NR;
            if (!win_found && req[p]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(p);
            end
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        busy_d       = busy_q;
        unit_start_d = 1'b0;
        unit_a_d     = unit_a_q;
        timer_d      = timer_q;
`ifndef CALC_ARB_FIXED_PRIO_EN
        last_d       = last_q;
        idx_d        = idx_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d        = N_REQ'(1) << win_idx;
                    unit_a_d     = req_a[win_idx*DATA_W +: DATA_W];
                    busy_d       = 1'b1;
                    unit_start_d = 1'b1;
`ifndef CALC_ARB_FIXED_PRIO_EN
                    idx_d        = win_idx;
`endif
                    state_d      = S_START;
                end
            end
            S_START: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done is checked first so it wins over a coinciding timeout.
                if (unit_done) begin
                    rsp_data_d  = unit_result;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = gnt_q;
                    state_d     = S_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = gnt_q;
                    state_d     = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
`ifndef CALC_ARB_FIXED_PRIO_EN
                last_d  = idx_q;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            unit_start_q <= 1'b0;
            unit_a_q     <= '0;
            timer_q      <= '0;
`ifndef CALC_ARB_FIXED_PRIO_EN
            last_q       <= IDX_W'(N_REQ - 1);
            idx_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
            unit_start_q <= unit_start_d;
            unit_a_q     <= unit_a_d;
            timer_q      <= timer_d;
`ifndef CALC_ARB_FIXED_PRIO_EN
            last_q       <= last_d;
            idx_q        <= idx_d;
`endif
        end
    end

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
    assign unit_start = unit_start_q;
    assign unit_a     = unit_a_q;

endmodule

// File: tb/tb_calc_op_arbiter.sv
// Directed bench for calc_op_arbiter: single op, rr alternation, timeout, done-at-timeout, reset abort, req drop.
module tb_calc_op_arbiter;

    localparam int N = 4;
    localparam int W = 7;

`ifdef CALC_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N-1:0]   gnt, rsp_valid;
    logic [W-1:0]   rsp_data, unit_a, unit_result;
    logic           rsp_err, busy, unit_start, unit_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    calc_op_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .unit_start(unit_start), .unit_a(unit_a),
        .unit_done(unit_done), .unit_result(unit_result)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; req = '0; unit_done = 1'b0; unit_result = '0;
        tick; tick;
        rst = 1'b1;
        tick;
    endtask

    // From the START cycle: n_idle WAIT cycles without done, then done; returns in RESP.
    task automatic finish_op(input int n_idle, input logic [W-1:0] res);
        tick;
        repeat (n_idle) tick;
        unit_done = 1'b1; unit_result = res;
        tick;
        unit_done = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; req = '0; req_a = '0; unit_done = 1'b0; unit_result = '0;
        #1;
        checks++; if ({gnt, rsp_valid} !== 8'h00) begin errors++; $display("FAIL reset_gnt_rsp: got %h want 00", {gnt, rsp_valid}); end
        checks++; if ({rsp_data, rsp_err, busy, unit_start, unit_a} !== 17'h0) begin errors++; $display("FAIL reset_misc: got %h want 0", {rsp_data, rsp_err, busy, unit_start, unit_a}); end
        tick;
        rst = 1'b1;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single;
        do_reset;
        req = 4'b0001; req_a = '0; req_a[0 +: W] = 7'd8;
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
        checks++; if (unit_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", unit_start); end
        checks++; if (unit_a !== 7'd8) begin errors++; $display("FAIL single_unit_a: got %0d want 8", unit_a); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        tick;
        checks++; if (unit_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b want 0", unit_start); end
        tick;
        unit_done = 1'b1; unit_result = 7'd3; req = '0;
        tick;
        unit_done = 1'b0;
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b want 0001", rsp_valid); end
        checks++; if (rsp_data !== 7'd3) begin errors++; $display("FAIL single_rsp_data: got %0d want 3", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp_err: got %b want 0", rsp_err); end
        tick;
        checks++; if ({rsp_valid, gnt, busy} !== 9'b0) begin errors++; $display("FAIL single_idle: got %b want 0", {rsp_valid, gnt, busy}); end
        checks++; if (rsp_data !== 7'd3) begin errors++; $display("FAIL single_hold: got %0d want 3", rsp_data); end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] exp;
        do_reset;
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            exp = (FIXED || (k % 2 == 0)) ? 4'b0001 : 4'b0100;
            tick;
            checks++; if (gnt !== exp) begin errors++; $display("FAIL b2b_gnt%0d: got %b want %b", k, gnt, exp); end
            tick;
            unit_done = 1'b1; unit_result = 7'(10 + k);
            tick;
            unit_done = 1'b0;
            checks++; if (rsp_valid !== exp || rsp_data !== 7'(10 + k)) begin
                errors++; $display("FAIL b2b_rsp%0d: got %b/%0d want %b/%0d", k, rsp_valid, rsp_data, exp, 10 + k);
            end
            if (k == 3) req = '0;
            tick;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", busy); end
    endtask

    task automatic test_timeout;
        req = 4'b0010; req_a[W +: W] = 7'd5;
        tick;
        checks++; if (gnt !== 4'b0010 || unit_a !== 7'd5) begin errors++; $display("FAIL to_gnt: got %b/%0d want 0010/5", gnt, unit_a); end
        req = '0;
        tick;
        repeat (14) tick;
        checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL to_early: got %b/%b want 0000/1", rsp_valid, busy); end
        tick;
        checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL to_rsp_valid: got %b want 0010", rsp_valid); end
        checks++; if (rsp_err !== 1'b1 || rsp_data !== 7'd0) begin errors++; $display("FAIL to_rsp: got %b/%0d want 1/0", rsp_err, rsp_data); end
        tick;
        checks++; if (rsp_valid !== 4'b0000 || rsp_err !== 1'b1) begin errors++; $display("FAIL to_hold: got %b/%b want 0000/1", rsp_valid, rsp_err); end
    endtask

    task automatic test_done_at_timeout;
        req = 4'b0100; req_a[2*W +: W] = 7'd9;
        tick;
        checks++; if (gnt !== 4'b0100 || unit_a !== 7'd9) begin errors++; $display("FAIL dat_gnt: got %b/%0d want 0100/9", gnt, unit_a); end
        req = '0;
        finish_op(14, 7'd5);
        checks++; if (rsp_valid !== 4'b0100 || rsp_err !== 1'b0 || rsp_data !== 7'd5) begin
            errors++; $display("FAIL dat_rsp: got %b/%b/%0d want 0100/0/5", rsp_valid, rsp_err, rsp_data);
        end
        tick;
    endtask

    task automatic test_reset_mid_op;
        req = 4'b0001; req_a[0 +: W] = 7'd4;
        tick; tick; tick;
        rst = 1'b0;
        #1;
        checks++; if ({gnt, busy, unit_start, unit_a} !== 13'b0) begin errors++; $display("FAIL rmid_ctl: got %h want 0", {gnt, busy, unit_start, unit_a}); end
        checks++; if ({rsp_data, rsp_err} !== 8'b0) begin errors++; $display("FAIL rmid_rsp: got %h want 0", {rsp_data, rsp_err}); end
        unit_done = 1'b1; unit_result = 7'd6;
        tick;
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rmid_no_rsp: got %b want 0000", rsp_valid); end
        unit_done = 1'b0;
        rst = 1'b1;
        req = 4'b1111;
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_first_gnt: got %b want 0001", gnt); end
        req = '0;
        finish_op(0, 7'd1);
        tick;
    endtask

    task automatic test_drop_req;
        req = 4'b1000; req_a[3*W +: W] = 7'd2;
        tick;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL drop_gnt: got %b want 1000", gnt); end
        tick;
        req = '0;
        tick; tick;
        unit_done = 1'b1; unit_result = 7'd7;
        tick;
        unit_done = 1'b0;
        checks++; if (rsp_valid !== 4'b1000 || rsp_data !== 7'd7) begin errors++; $display("FAIL drop_rsp: got %b/%0d want 1000/7", rsp_valid, rsp_data); end
        tick;
        req = 4'b1001;
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL drop_next_gnt: got %b want 0001", gnt); end
        req = '0;
        finish_op(0, 7'd0);
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_timeout;
        test_done_at_timeout;
        test_reset_mid_op;
        test_drop_req;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
